// File: rtl/rom_playback_ctrl.sv
// rtl/rom_playback_ctrl.sv - steps ROM samples into the audio codec, one word per write_ready handshake
module rom_playback_ctrl #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 24,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 16'hFFFF,
    parameter int                ROM_LAT   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              busy,
    output logic              done
);

    localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        WAIT_ROM = 2'd2,
        PRESENT  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic [DATA_W-1:0] sample_q;
    logic              done_q;
    logic              at_last;

    assign at_last = (addr_q == LAST_ADDR);
    // Wrap and one-shot completion both park the address at 0.
    assign addr_d  = at_last ? '0 : addr_q + ADDR_W'(1);

    assign write           = (state_q == PRESENT) & write_ready & ~stop;
    assign rom_address     = addr_q;
    assign writedata_left  = sample_q;
    assign writedata_right = sample_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            lat_cnt_q <= '0;
            sample_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // stop outranks start and any pending handshake in every active state.
            if (stop && (state_q != IDLE)) begin
                state_q   <= IDLE;
                addr_q    <= '0;
                lat_cnt_q <= '0;
                sample_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        addr_q   <= '0;
                        sample_q <= '0;
                        if (start && !stop) begin
                            state_q <= FETCH;
                        end
                    end
                    FETCH: begin
                        lat_cnt_q <= '0;
                        state_q   <= WAIT_ROM;
                    end
                    WAIT_ROM: begin
                        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                        if (lat_cnt_q == LAT_W'(ROM_LAT - 1)) begin
                            sample_q <= rom_q;
                            state_q  <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (write_ready) begin
                            addr_q <= addr_d;
                            if (at_last && !loop) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                state_q <= FETCH;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_playback_ctrl.sv
// tb/tb_rom_playback_ctrl.sv - directed self-checking bench for rom_playback_ctrl
module tb_rom_playback_ctrl;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        loop;
    logic [15:0] rom_address;
    logic [23:0] rom_q;
    logic        write_ready;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;
    logic        busy;
    logic        done;

    logic [23:0] rom_p1;
    logic [23:0] rom_p2;
    logic [23:0] exp_data [4];

    int n_checks;
    int n_fail;

    rom_playback_ctrl #(
        .ADDR_W   (16),
        .DATA_W   (24),
        .LAST_ADDR(16'd3),
        .ROM_LAT  (2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .loop           (loop),
        .rom_address    (rom_address),
        .rom_q          (rom_q),
        .write_ready    (write_ready),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .busy           (busy),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Two-cycle ROM: q = addr * 0x0101
    always @(posedge clock) begin
        rom_p1 <= 24'(rom_address) * 24'h000101;
        rom_p2 <= rom_p1;
    end
    assign rom_q = rom_p2;

    task automatic wait_write(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (write) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        logic ok;
        n_checks++;
        if ({write, busy, done} !== 3'b000 || rom_address !== 16'd0 || writedata_left !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_state: write=%b busy=%b done=%b addr=%h data=%h, required all 0",
                     write, busy, done, rom_address, writedata_left);
        end
        loop = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_write(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_reach_present: no write seen, required a write");
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({write, busy, done} !== 3'b000 || rom_address !== 16'd0 ||
            writedata_left !== 24'd0 || writedata_right !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_async: write=%b busy=%b done=%b addr=%h data=%h, required all 0",
                     write, busy, done, rom_address, writedata_left);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_checks++;
            if (busy !== 1'b0 || write !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_idle: busy=%b write=%b, required 0 0", busy, write);
            end
        end
    endtask

    task automatic test_one_shot();
        int nw = 0;
        int first_c = -1;
        int last_c = -1;
        int ndone = 0;
        int done_c = -1;
        logic busy_at_done = 1'b1;
        loop = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (write) begin
                n_checks++;
                if (nw > 3 || writedata_left !== exp_data[nw & 3] || writedata_right !== writedata_left) begin
                    n_fail++;
                    $display("FAIL one_shot_data[%0d]: left=%h right=%h, required %h on both",
                             nw, writedata_left, writedata_right, exp_data[nw & 3]);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                nw++;
            end
            if (done) begin
                ndone++;
                done_c = c;
                busy_at_done = busy;
            end
            @(negedge clock);
        end
        n_checks++;
        if (nw != 4) begin
            n_fail++;
            $display("FAIL one_shot_count: writes=%0d, required 4", nw);
        end
        n_checks++;
        if (first_c != 4) begin
            n_fail++;
            $display("FAIL one_shot_latency: first write at cycle %0d, required 4", first_c);
        end
        n_checks++;
        if (ndone != 1 || done_c != last_c + 1 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL one_shot_done: pulses=%0d at=%0d busy=%b, required 1 at %0d busy=0",
                     ndone, done_c, busy_at_done, last_c + 1);
        end
    endtask

    task automatic test_loop();
        int nw = 0;
        int ndone = 0;
        loop = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (write) begin
                n_checks++;
                if (writedata_left !== exp_data[nw & 3]) begin
                    n_fail++;
                    $display("FAIL loop_data[%0d]: data=%h, required %h", nw, writedata_left, exp_data[nw & 3]);
                end
                nw++;
            end
            if (done) ndone++;
            @(negedge clock);
        end
        n_checks++;
        if (nw < 9 || ndone != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_wrap: writes=%0d done=%0d busy=%b, required >=9 0 1", nw, ndone, busy);
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        loop = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_stop: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        int nw = 0;
        loop = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_write(ok);
        @(negedge clock);
        wait_write(ok);
        n_checks++;
        if (!ok || writedata_left !== 24'h000101) begin
            n_fail++;
            $display("FAIL bp_setup: ok=%b data=%h, required 1 000101", ok, writedata_left);
        end
        @(negedge clock);
        write_ready = 1'b0;
        for (int c = 0; c < 13; c++) begin
            if (write) nw++;
            @(negedge clock);
        end
        n_checks++;
        if (nw != 0 || writedata_left !== 24'h000202 || rom_address !== 16'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: writes=%0d data=%h addr=%h busy=%b, required 0 000202 0002 1",
                     nw, writedata_left, rom_address, busy);
        end
        write_ready = 1'b1;
        #1;
        n_checks++;
        if (write !== 1'b1 || writedata_left !== 24'h000202) begin
            n_fail++;
            $display("FAIL bp_release: write=%b data=%h, required 1 000202", write, writedata_left);
        end
        @(negedge clock);
        n_checks++;
        if (rom_address !== 16'd3 || write !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_addr: addr=%h write=%b, required 0003 0", rom_address, write);
        end
        for (int c = 0; c < 20 && busy; c++) @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_stop();
        logic ok;
        loop = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_write(ok);
        @(negedge clock);
        wait_write(ok);
        stop = 1'b1;
        #1;
        n_checks++;
        if (!ok || write !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_blocks_write: ok=%b write=%b, required 1 0", ok, write);
        end
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || rom_address !== 16'd0 || writedata_left !== 24'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: busy=%b addr=%h data=%h done=%b, required 0 0000 000000 0",
                     busy, rom_address, writedata_left, done);
        end
        stop = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_start_ignored();
        logic ok;
        loop = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_write(ok);
        @(negedge clock);
        wait_write(ok);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_write(ok);
        n_checks++;
        if (!ok || writedata_left !== 24'h000202) begin
            n_fail++;
            $display("FAIL start_while_busy: ok=%b data=%h, required 1 000202", ok, writedata_left);
        end
        for (int c = 0; c < 20 && busy; c++) @(negedge clock);
        @(negedge clock);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (busy !== 1'b0 || write !== 1'b0) begin
                n_fail++;
                $display("FAIL start_stop_idle: busy=%b write=%b, required 0 0", busy, write);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_data[0] = 24'h000000;
        exp_data[1] = 24'h000101;
        exp_data[2] = 24'h000202;
        exp_data[3] = 24'h000303;
        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loop = 1'b0;
        write_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        test_reset();
        test_one_shot();
        test_loop();
        test_backpressure();
        test_stop();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
